// File: rtl/alu_driver.sv
// Sequential valid/ready front-end for the 8-bit combinational ALU: registers a command onto
// the ALU inputs, captures Y and flags one cycle later, and holds them until consumed.
// The optional accumulator operand is enabled by defining ALU_DRV_ACC_EN.
//
// Handshakes: a command transfers on an edge with CMD_VALID & CMD_READY, a result on an edge
// with RES_VALID & RES_READY; both READY/VALID outputs decode from the state register only.
module alu_driver (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [2:0] CMD_OP,
  input  logic [7:0] CMD_A,
  input  logic [7:0] CMD_B,
  input  logic       CMD_ACC,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  output logic [2:0] ALU_OP,
  input  logic [7:0] ALU_Y,
  input  logic       ALU_C,
  input  logic       ALU_V,
  input  logic       ALU_N,
  input  logic       ALU_Z,
  output logic       RES_VALID,
  input  logic       RES_READY,
  output logic [7:0] RES_Y,
  output logic [3:0] RES_FLAGS,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic [7:0] res_y_q, res_y_d;
  logic [3:0] res_flags_q, res_flags_d;
  logic [7:0] opa_sel;

`ifdef ALU_DRV_ACC_EN
  logic [7:0] acc_q, acc_d;

  assign opa_sel = CMD_ACC ? acc_q : CMD_A;
`else
  logic unused_cmd_acc;

  assign unused_cmd_acc = CMD_ACC;
  assign opa_sel        = CMD_A;
`endif

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_y_d     = res_y_q;
    res_flags_d = res_flags_q;
`ifdef ALU_DRV_ACC_EN
    acc_d       = acc_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          alu_a_d  = opa_sel;
          alu_b_d  = CMD_B;
          alu_op_d = CMD_OP;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // ALU output settles from the registered operands during this cycle.
        res_y_d     = ALU_Y;
        res_flags_d = {ALU_C, ALU_V, ALU_N, ALU_Z};
`ifdef ALU_DRV_ACC_EN
        acc_d       = ALU_Y;
`endif
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (RES_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      alu_op_q    <= 3'b000;
      res_y_q     <= 8'h00;
      res_flags_q <= 4'b0000;
`ifdef ALU_DRV_ACC_EN
      acc_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_y_q     <= res_y_d;
      res_flags_q <= res_flags_d;
`ifdef ALU_DRV_ACC_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign CMD_READY = (state_q == ST_IDLE);
  assign RES_VALID = (state_q == ST_HOLD);
  assign BUSY      = (state_q != ST_IDLE);
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_OP    = alu_op_q;
  assign RES_Y     = res_y_q;
  assign RES_FLAGS = res_flags_q;

endmodule
